// File: rtl/up_down_mon_pkg.sv
// Event codes and event-word sizing shared by the wrap monitor and its FIFO.
// Pure definitions: no latency, no flow control.
package up_down_mon_pkg;

  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_WRAP_UP = 2'b01;
  localparam logic [1:0] EVT_WRAP_DN = 2'b10;
  localparam logic [1:0] EVT_DIR_CHG = 2'b11;

  // Event word is {type[1:0], timestamp}.
  function automatic int evt_word_w(input int ts_w);
    return 2 + ts_w;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Register-based event FIFO: push visible at the head one cycle later.
// Push while full is refused unless a pop happens on the same edge; pop while empty is ignored.
module evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign pop_ok   = pop && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/up_down_wrap_monitor.sv
// Counter monitor: flags wraps/direction changes, time-stamps them into a FIFO (valid next cycle).
// Consumer backpressure via evt_ready; events arriving at a full FIFO are dropped and flagged in ovf.
module up_down_wrap_monitor
  import up_down_mon_pkg::*;
#(
  parameter int W       = 3,
  parameter int TS_W    = 8,
  parameter int DEPTH   = 4,
  parameter int TALLY_W = 8,
  localparam int EW = evt_word_w(TS_W),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [W-1:0]       count_in,
  input  logic               mode_in,
  input  logic               evt_ready,
  input  logic               clr,
  output logic               evt_valid,
  output logic [EW-1:0]      evt_data,
  output logic [LW-1:0]      evt_level,
  output logic [TALLY_W-1:0] wrap_up_n,
  output logic [TALLY_W-1:0] wrap_dn_n,
  output logic               ovf
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]    ts_q, ts_d;
  logic [W-1:0]       prev_q, prev_d;
  logic               prev_mode_q, prev_mode_d;
  logic               prev_vld_q, prev_vld_d;
  logic [TALLY_W-1:0] tally_up_q, tally_up_d;
  logic [TALLY_W-1:0] tally_dn_q, tally_dn_d;
  logic               ovf_q, ovf_d;

  logic [1:0]         evt_type;
  logic               evt_push;
  logic               fifo_full, fifo_empty;
  logic               drop;

  // Wraps outrank a direction change seen on the same sample.
  always_comb begin
    evt_type = EVT_NONE;
    if (en && prev_vld_q) begin
      if (prev_q == CNT_MAX && count_in == '0 && mode_in)
        evt_type = EVT_WRAP_UP;
      else if (prev_q == '0 && count_in == CNT_MAX && !mode_in)
        evt_type = EVT_WRAP_DN;
      else if (mode_in != prev_mode_q)
        evt_type = EVT_DIR_CHG;
    end
  end

  assign evt_push = (evt_type != EVT_NONE);
  assign drop     = evt_push && fifo_full && !(evt_valid && evt_ready);

  always_comb begin
    ts_d        = ts_q + TS_W'(1);
    prev_d      = prev_q;
    prev_mode_d = prev_mode_q;
    prev_vld_d  = prev_vld_q;
    tally_up_d  = tally_up_q;
    tally_dn_d  = tally_dn_q;
    ovf_d       = ovf_q;

    if (en) begin
      prev_d      = count_in;
      prev_mode_d = mode_in;
      prev_vld_d  = 1'b1;
    end

    if (clr) begin
      tally_up_d = '0;
      tally_dn_d = '0;
    end else begin
      if (evt_type == EVT_WRAP_UP && tally_up_q != '1) tally_up_d = tally_up_q + TALLY_W'(1);
      if (evt_type == EVT_WRAP_DN && tally_dn_q != '1) tally_dn_d = tally_dn_q + TALLY_W'(1);
    end

    if (drop)     ovf_d = 1'b1;
    else if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q        <= '0;
      prev_q      <= '0;
      prev_mode_q <= 1'b0;
      prev_vld_q  <= 1'b0;
      tally_up_q  <= '0;
      tally_dn_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      prev_q      <= prev_d;
      prev_mode_q <= prev_mode_d;
      prev_vld_q  <= prev_vld_d;
      tally_up_q  <= tally_up_d;
      tally_dn_q  <= tally_dn_d;
      ovf_q       <= ovf_d;
    end
  end

  evt_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (evt_push),
    .push_data ({evt_type, ts_q}),
    .full      (fifo_full),
    .pop       (evt_ready),
    .pop_data  (evt_data),
    .empty     (fifo_empty),
    .level     (evt_level)
  );

  assign evt_valid = !fifo_empty;
  assign wrap_up_n = tally_up_q;
  assign wrap_dn_n = tally_dn_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_up_down_wrap_monitor.sv
// Directed bench for up_down_wrap_monitor (W=3, TS_W=8, DEPTH=4); timestamps counted from reset release.
module tb_up_down_wrap_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] count_in = 3'd0;
  logic       mode_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       clr = 1'b0;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic [2:0] evt_level;
  logic [7:0] wrap_up_n;
  logic [7:0] wrap_dn_n;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  up_down_wrap_monitor #(.W(3), .TS_W(8), .DEPTH(4), .TALLY_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .count_in  (count_in),
    .mode_in   (mode_in),
    .evt_ready (evt_ready),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_level (evt_level),
    .wrap_up_n (wrap_up_n),
    .wrap_dn_n (wrap_dn_n),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [2:0] c, input logic m);
    count_in = c;
    mode_in  = m;
    tick();
  endtask

  // Leaves rst released just after an edge, so the next edge samples ts=0.
  task automatic do_reset();
    en = 1'b0; clr = 1'b0; evt_ready = 1'b0; count_in = 3'd0; mode_in = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", evt_valid); end
    checks++; if (evt_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", evt_level); end
    checks++; if (evt_data !== 10'h000) begin errors++; $display("FAIL rst_data got %h exp 000", evt_data); end
    checks++; if (wrap_up_n !== 8'd0 || wrap_dn_n !== 8'd0) begin errors++; $display("FAIL rst_tally got %0d/%0d exp 0/0", wrap_up_n, wrap_dn_n); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_up_wrap();
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    smp(3'd5, 1'b1); smp(3'd6, 1'b1); smp(3'd7, 1'b1);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL up_quiet got %b exp 0", evt_valid); end
    smp(3'd0, 1'b1);
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL up_valid got %b exp 1", evt_valid); end
    checks++; if (evt_data !== 10'h103) begin errors++; $display("FAIL up_data got %h exp 103", evt_data); end
    checks++; if (evt_level !== 3'd1) begin errors++; $display("FAIL up_level got %0d exp 1", evt_level); end
    checks++; if (wrap_up_n !== 8'd1) begin errors++; $display("FAIL up_tally got %0d exp 1", wrap_up_n); end
    smp(3'd1, 1'b1);
    checks++; if (evt_valid !== 1'b0 || evt_level !== 3'd0) begin errors++; $display("FAIL up_pop got %b/%0d exp 0/0", evt_valid, evt_level); end
  endtask

  task automatic test_down_wrap();
    do_reset();
    en = 1'b1;
    smp(3'd1, 1'b0); smp(3'd0, 1'b0); smp(3'd7, 1'b0);
    checks++; if (evt_data !== 10'h202) begin errors++; $display("FAIL dn_data got %h exp 202", evt_data); end
    checks++; if (wrap_dn_n !== 8'd1 || wrap_up_n !== 8'd0) begin errors++; $display("FAIL dn_tally got %0d/%0d exp 0/1", wrap_up_n, wrap_dn_n); end
    smp(3'd6, 1'b0);
    checks++; if (evt_level !== 3'd1) begin errors++; $display("FAIL dn_level got %0d exp 1", evt_level); end
  endtask

  task automatic test_wrap_dir();
    do_reset();
    en = 1'b1;
    smp(3'd1, 1'b1); smp(3'd0, 1'b1);
    smp(3'd7, 1'b0);
    smp(3'd6, 1'b0); smp(3'd5, 1'b0);
    checks++; if (evt_level !== 3'd1) begin errors++; $display("FAIL wd_suppress got %0d exp 1", evt_level); end
    smp(3'd7, 1'b1);
    smp(3'd0, 1'b0);
    checks++; if (evt_level !== 3'd3) begin errors++; $display("FAIL wd_level got %0d exp 3", evt_level); end
    checks++; if (wrap_up_n !== 8'd0 || wrap_dn_n !== 8'd1) begin errors++; $display("FAIL wd_tally got %0d/%0d exp 0/1", wrap_up_n, wrap_dn_n); end
    en = 1'b0; evt_ready = 1'b1;
    checks++; if (evt_data !== 10'h202) begin errors++; $display("FAIL wd_head0 got %h exp 202", evt_data); end
    tick();
    checks++; if (evt_data !== 10'h305) begin errors++; $display("FAIL wd_head1 got %h exp 305", evt_data); end
    tick();
    checks++; if (evt_data !== 10'h306) begin errors++; $display("FAIL wd_head2 got %h exp 306", evt_data); end
    tick();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL wd_drained got %b exp 0", evt_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    en = 1'b1; mode_in = 1'b1;
    smp(3'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      smp(3'd0, 1'b1);
      smp(3'd7, 1'b1);
    end
    checks++; if (evt_level !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL of_full got %0d/%b exp 4/0", evt_level, ovf); end
    smp(3'd0, 1'b1);
    checks++; if (evt_level !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL of_drop got %0d/%b exp 4/1", evt_level, ovf); end
    checks++; if (wrap_up_n !== 8'd5) begin errors++; $display("FAIL of_tally got %0d exp 5", wrap_up_n); end
    checks++; if (evt_data !== 10'h101) begin errors++; $display("FAIL of_head got %h exp 101", evt_data); end
    clr = 1'b1;
    smp(3'd7, 1'b1);
    clr = 1'b0;
    checks++; if (ovf !== 1'b0 || wrap_up_n !== 8'd0) begin errors++; $display("FAIL of_clr got %b/%0d exp 0/0", ovf, wrap_up_n); end
    evt_ready = 1'b1;
    smp(3'd0, 1'b1);
    checks++; if (evt_level !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL of_pushpop got %0d/%b exp 4/0", evt_level, ovf); end
    checks++; if (evt_data !== 10'h103 || wrap_up_n !== 8'd1) begin errors++; $display("FAIL of_pp_head got %h/%0d exp 103/1", evt_data, wrap_up_n); end
    evt_ready = 1'b0;
    smp(3'd7, 1'b1);
    clr = 1'b1;
    smp(3'd0, 1'b1);
    clr = 1'b0;
    checks++; if (ovf !== 1'b1 || wrap_up_n !== 8'd0) begin errors++; $display("FAIL of_clr_drop got %b/%0d exp 1/0", ovf, wrap_up_n); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1;
    smp(3'd7, 1'b1); smp(3'd0, 1'b1); smp(3'd7, 1'b1); smp(3'd0, 1'b1);
    checks++; if (evt_level !== 3'd2) begin errors++; $display("FAIL rm_queued got %0d exp 2", evt_level); end
    rst = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0 || evt_level !== 3'd0) begin errors++; $display("FAIL rm_async got %b/%0d exp 0/0", evt_valid, evt_level); end
    checks++; if (wrap_up_n !== 8'd0) begin errors++; $display("FAIL rm_tally got %0d exp 0", wrap_up_n); end
    tick();
    rst = 1'b1;
    smp(3'd7, 1'b0);
    checks++; if (evt_valid !== 1'b0 || evt_level !== 3'd0) begin errors++; $display("FAIL rm_first got %b/%0d exp 0/0", evt_valid, evt_level); end
  endtask

  task automatic test_enable_clr();
    do_reset();
    en = 1'b1;
    smp(3'd5, 1'b1); smp(3'd6, 1'b1);
    en = 1'b0;
    smp(3'd7, 1'b1);
    en = 1'b1;
    smp(3'd0, 1'b1);
    checks++; if (evt_level !== 3'd0 || wrap_up_n !== 8'd0) begin errors++; $display("FAIL en_skip got %0d/%0d exp 0/0", evt_level, wrap_up_n); end
    smp(3'd7, 1'b1); smp(3'd0, 1'b1);
    checks++; if (evt_data !== 10'h105 || wrap_up_n !== 8'd1) begin errors++; $display("FAIL en_wrap got %h/%0d exp 105/1", evt_data, wrap_up_n); end
    smp(3'd7, 1'b1);
    clr = 1'b1;
    smp(3'd0, 1'b1);
    clr = 1'b0;
    checks++; if (wrap_up_n !== 8'd0 || evt_level !== 3'd2) begin errors++; $display("FAIL en_clr got %0d/%0d exp 0/2", wrap_up_n, evt_level); end
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    smp(3'd7, 1'b1);
    for (int i = 0; i < 260; i++) begin
      smp(3'd0, 1'b1);
      smp(3'd7, 1'b1);
    end
    checks++; if (wrap_up_n !== 8'hFF || ovf !== 1'b0) begin errors++; $display("FAIL sat_tally got %0d/%b exp 255/0", wrap_up_n, ovf); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_wrap_dir();
    test_overflow();
    test_reset_mid();
    test_enable_clr();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
